// File: rtl/register_file_mw.sv
// Multi-port integer register file with async reset-clear, optional
// write-to-read bypass and a per-register busy scoreboard for RAW hazard detection.
module register_file_mw #(
  parameter int XLEN     = 32,
  parameter int N_REGS   = 32,
  parameter int N_RPORTS = 2,
  parameter int N_WPORTS = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW = $clog2(N_REGS),
  localparam int CW = $clog2(N_REGS + 1)
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [N_WPORTS-1:0]                i_we,
  input  logic [N_WPORTS-1:0][AW-1:0]        i_waddr,
  input  logic [N_WPORTS-1:0][XLEN-1:0]      i_wdata,
  input  logic [N_RPORTS-1:0][AW-1:0]        i_raddr,
  output logic [N_RPORTS-1:0][XLEN-1:0]      o_rdata,
  output logic [N_RPORTS-1:0]                o_busy,
  input  logic                               i_rsv,
  input  logic [AW-1:0]                      i_rsv_addr,
  output logic [CW-1:0]                      o_busy_count
);

  logic [XLEN-1:0]   regs [N_REGS];
  logic [N_REGS-1:0] busy;
  logic [N_REGS-1:0] set_vec;
  logic [N_REGS-1:0] clr_vec;
  logic [N_REGS-1:0] busy_next;
  logic [CW-1:0]     n_set;
  logic [CW-1:0]     n_clr;
  logic [CW-1:0]     count;

  // Scoreboard next state; a reserve outranks a release on the same register.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    set_vec = '0;
    clr_vec = '0;
    n_set   = '0;
    n_clr   = '0;
    if (i_rsv && !(ZERO_REG != 0 && i_rsv_addr == '0)) set_vec[i_rsv_addr] = 1'b1;
    for (int p = 0; p < N_WPORTS; p++) begin
      if (i_we[p]) clr_vec[i_waddr[p]] = 1'b1;
    end
    busy_next = (busy & ~clr_vec) | set_vec;
    for (int i = 0; i < N_REGS; i++) begin
      n_set = n_set + CW'(set_vec[i] & ~busy[i]);
      n_clr = n_clr + CW'(busy[i] & clr_vec[i] & ~set_vec[i]);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      busy  <= '0;
      count <= '0;
    end else begin
      busy  <= busy_next;
      count <= count + n_set - n_clr;
    end
  end

  // NOTE: the storage array is cleared on reset because software relies on
  // all-zero registers after reset; this keeps it in flops rather than RAM.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
    end else begin
      // NOTE: non-blocking updates in port order let the highest-index port land last and win.
      for (int p = 0; p < N_WPORTS; p++) begin
        if (i_we[p] && !(ZERO_REG != 0 && i_waddr[p] == '0)) regs[i_waddr[p]] <= i_wdata[p];
      end
    end
  end

  always_comb begin
    o_rdata = '0;
    o_busy  = '0;
    for (int r = 0; r < N_RPORTS; r++) begin
      o_rdata[r] = regs[i_raddr[r]];
      o_busy[r]  = busy[i_raddr[r]];
      if (ZERO_REG != 0 && i_raddr[r] == '0) begin
        o_rdata[r] = '0;
      end else if (BYPASS != 0) begin
        // Forwarded data is ready now, so the consumer need not stall.
        for (int p = 0; p < N_WPORTS; p++) begin
          if (i_we[p] && i_waddr[p] == i_raddr[r]) begin
            o_rdata[r] = i_wdata[p];
            o_busy[r]  = 1'b0;
          end
        end
      end
    end
  end

  assign o_busy_count = count;

endmodule

// File: tb/tb_register_file_mw.sv
// Self-checking bench: two register files (bypass+zero-reg, and plain) share
// stimulus and are compared each cycle against a behavioural array model.
module tb_register_file_mw;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [1:0]            we;
  logic [1:0][4:0]       waddr;
  logic [1:0][31:0]      wdata;
  logic [1:0][4:0]       raddr;
  logic                  rsv;
  logic [4:0]            rsv_addr;
  logic [1:0][31:0]      rdata_a, rdata_b;
  logic [1:0]            busy_a, busy_b;
  logic [5:0]            cnt_a, cnt_b;

  int checks = 0;
  int errors = 0;

  // Model state per configuration: 0 = BYPASS 1 / ZERO_REG 1, 1 = BYPASS 0 / ZERO_REG 0.
  logic [31:0] m_mem  [2][32];
  bit          m_busy [2][32];
  bit          cfg_byp  [2] = '{1'b1, 1'b0};
  bit          cfg_zero [2] = '{1'b1, 1'b0};

  always #5 clk = ~clk;

  register_file_mw dut_a (
    .i_clk(clk), .i_rst(rst), .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
    .i_raddr(raddr), .o_rdata(rdata_a), .o_busy(busy_a),
    .i_rsv(rsv), .i_rsv_addr(rsv_addr), .o_busy_count(cnt_a)
  );

  register_file_mw #(.BYPASS(0), .ZERO_REG(0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
    .i_raddr(raddr), .o_rdata(rdata_b), .o_busy(busy_b),
    .i_rsv(rsv), .i_rsv_addr(rsv_addr), .o_busy_count(cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rdata(int c, int r);
    if (cfg_zero[c] && raddr[r] == 5'd0) return 32'd0;
    if (cfg_byp[c]) begin
      for (int p = 1; p >= 0; p--)
        if (we[p] && waddr[p] == raddr[r]) return wdata[p];
    end
    return m_mem[c][raddr[r]];
  endfunction

  function automatic logic [31:0] exp_busy(int c, int r);
    if (cfg_zero[c] && raddr[r] == 5'd0) return 32'd0;
    if (cfg_byp[c]) begin
      for (int p = 0; p < 2; p++)
        if (we[p] && waddr[p] == raddr[r]) return 32'd0;
    end
    return {31'd0, m_busy[c][raddr[r]]};
  endfunction

  function automatic logic [31:0] exp_count(int c);
    int n = 0;
    foreach (m_busy[c][i]) n += int'(m_busy[c][i]);
    return n;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 32; i++) begin
        m_mem[c][i]  = '0;
        m_busy[c][i] = 1'b0;
      end
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else begin
      for (int c = 0; c < 2; c++) begin
        for (int p = 0; p < 2; p++)
          if (we[p] && !(cfg_zero[c] && waddr[p] == 5'd0)) m_mem[c][waddr[p]] = wdata[p];
        for (int p = 0; p < 2; p++)
          if (we[p]) m_busy[c][waddr[p]] = 1'b0;
        if (rsv && !(cfg_zero[c] && rsv_addr == 5'd0)) m_busy[c][rsv_addr] = 1'b1;
      end
    end
  endtask

  task automatic check_outputs(input string where);
    for (int r = 0; r < 2; r++) begin
      check($sformatf("%s a rdata%0d", where, r), rdata_a[r], exp_rdata(0, r));
      check($sformatf("%s b rdata%0d", where, r), rdata_b[r], exp_rdata(1, r));
      check($sformatf("%s a busy%0d", where, r), {31'd0, busy_a[r]}, exp_busy(0, r));
      check($sformatf("%s b busy%0d", where, r), {31'd0, busy_b[r]}, exp_busy(1, r));
    end
    check($sformatf("%s a count", where), {26'd0, cnt_a}, exp_count(0));
    check($sformatf("%s b count", where), {26'd0, cnt_b}, exp_count(1));
  endtask

  // Inputs are applied at posedge+1; outputs are sampled at posedge+2.
  task automatic cycle(input string where);
    #1 check_outputs(where);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    we = '0; waddr = '0; wdata = '0; rsv = 1'b0; rsv_addr = '0;
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    we[p] = 1'b1; waddr[p] = a; wdata[p] = d;
  endtask

  task automatic reserve(input logic [4:0] a);
    rsv = 1'b1; rsv_addr = a;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    raddr = '0;
    model_reset();
    @(posedge clk);
    #1 check_outputs("reset");
    rst = 1'b0;

    // 1: write, async reset mid-cycle, writes ignored under reset, then rewrite.
    wr(0, 5'd5, 32'h12345600); raddr = {5'd5, 5'd5};
    cycle("t1_wr");
    idle();
    #1 check_outputs("t1_stored");
    rst = 1'b1;
    model_reset();
    #1 check_outputs("t1_async_rst");
    check("t1_x5_zero", rdata_a[0], 32'd0);
    wr(0, 5'd5, 32'hDEADBEEF); reserve(5'd5);
    cycle("t1_in_rst");
    rst = 1'b0;
    idle();
    cycle("t1_after_rst");
    wr(0, 5'd5, 32'h12345600);
    cycle("t1_wr2");
    idle();
    cycle("t1_rd");
    check("t1_x5_value", rdata_a[0], 32'h12345600);

    // 2: two ports write x3 in one cycle.
    wr(0, 5'd3, 32'hAAAA0000); wr(1, 5'd3, 32'hBBBB0000); raddr = {5'd3, 5'd3};
    cycle("t2_conflict");
    idle();
    cycle("t2_rd");
    check("t2_x3_value", rdata_b[1], 32'hBBBB0000);

    // 3: register 0 write and reserve.
    wr(0, 5'd0, 32'hccddeeff); reserve(5'd0); raddr = {5'd5, 5'd0};
    cycle("t3_x0");
    idle();
    cycle("t3_rd");
    check("t3_b_x0", rdata_b[0], 32'hccddeeff);

    // 4: scoreboard sequence on x7 and x9.
    reserve(5'd7); raddr = {5'd9, 5'd7};
    cycle("t4_rsv7");
    cycle("t4_rsv7_again");
    reserve(5'd9);
    cycle("t4_rsv9");
    idle(); wr(0, 5'd7, 32'h00000001);
    cycle("t4_wr7");
    idle();
    cycle("t4_after");
    check("t4_a_count", {26'd0, cnt_a}, 32'd1);

    // 5: same-cycle reserve and write, then double release.
    reserve(5'd4); raddr = {5'd9, 5'd4};
    cycle("t5_rsv4");
    reserve(5'd9);
    cycle("t5_rsv9");
    idle(); reserve(5'd4); wr(0, 5'd4, 32'h00000044);
    cycle("t5_rsv_wr4");
    idle();
    cycle("t5_after");
    wr(0, 5'd4, 32'h44440000); wr(1, 5'd9, 32'h99990000);
    cycle("t5_release2");
    idle();
    cycle("t5_after2");

    // 6: fill every non-zero register, then drain two per cycle.
    for (int a = 1; a < 32; a++) begin
      idle(); reserve(5'(a)); raddr = {5'(a), 5'(a - 1)};
      cycle($sformatf("t6_fill%0d", a));
    end
    idle();
    cycle("t6_full");
    check("t6_a_full", {26'd0, cnt_a}, 32'd31);
    for (int a = 1; a < 32; a += 2) begin
      idle(); wr(0, 5'(a), 32'(a)); wr(1, 5'((a + 1) % 32), 32'(a + 1));
      raddr = {5'(a), 5'((a + 1) % 32)};
      cycle($sformatf("t6_drain%0d", a));
    end
    idle();
    cycle("t6_empty");
    check("t6_a_empty", {26'd0, cnt_a}, 32'd0);

    // Random traffic with addresses biased toward a small window to force conflicts.
    for (int i = 0; i < 400; i++) begin
      we = 2'($urandom);
      for (int p = 0; p < 2; p++) begin
        waddr[p] = ($urandom % 2) ? 5'($urandom_range(0, 7)) : 5'($urandom);
        wdata[p] = $urandom;
        raddr[p] = ($urandom % 2) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      end
      rsv      = ($urandom % 3) != 0;
      rsv_addr = ($urandom % 2) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      if (i % 97 == 96) begin
        rst = 1'b1;
        model_reset();
        #1 check_outputs("rnd_rst");
        #1 rst = 1'b0;
      end
      cycle($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
